// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer around an external combinational 1-bit full adder; optional ovf via SERIAL_ADD_OVF_EN.
// Latency: start accepted at E0, result and done appear after E(WIDTH); one operation per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, requests in SHIFT/DONE are dropped, not queued.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             add_x,
    output logic             add_y,
    output logic             add_cin,
    input  logic             add_z,
    input  logic             add_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        add_x   = 1'b0;
        add_y   = 1'b0;
        add_cin = 1'b0;
        if (state == SHIFT) begin
            add_x   = opa[0];
            add_y   = opb[0];
            add_cin = carry;
        end
    end

    // Datapath: operand shifters, running carry, sum accumulator and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (start) begin
                opa   <= a;
                opb   <= b;
                carry <= cin_init;
                acc   <= '0;
                cnt   <= '0;
            end
        end else if (state == SHIFT) begin
            acc   <= {add_z, acc[WIDTH-1:1]};
            carry <= add_cout;
            opa   <= {1'b0, opa[WIDTH-1:1]};
            opb   <= {1'b0, opb[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                sum  <= {add_z, acc[WIDTH-1:1]};
                cout <= add_cout;
`ifdef SERIAL_ADD_OVF_EN
                // carry still holds the carry into the MSB at this edge
                ovf  <= carry ^ add_cout;
`endif
            end
        end
    end

endmodule
